// File: rtl/pcie_tx_pkg.sv
// Shared encodings, credit vector type and credit helpers for the PCIe TX arbiter.
package pcie_tx_pkg;

   localparam int TO_CYCLES_DEF = 255;

   typedef enum logic [1:0] {
      CLS_P   = 2'd0,
      CLS_NP  = 2'd1,
      CLS_CPL = 2'd2,
      CLS_ILL = 2'd3
   } tlp_cls_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [8:0]  ph;
      logic [8:0]  nph;
      logic [8:0]  cplh;
      logic [12:0] pd;
      logic [12:0] npd;
      logic [12:0] cpld;
   } credit_t;

   // Header credit is usable when non-zero; the MSB alone already means infinite.
   function automatic logic hdr_ok(input logic [8:0] hdr);
      return hdr[8] | (hdr[7:0] != 8'd0);
   endfunction

   function automatic logic data_ok(input logic [12:0] avail, input logic [7:0] need);
      return avail[12] | (avail >= {5'd0, need});
   endfunction

endpackage

// File: rtl/pcie_credit_chk.sv
// Eligibility of one requester: selects the class credits and compares them with its needs.
module pcie_credit_chk
   import pcie_tx_pkg::*;
(
   input  tlp_cls_e   cls,
   input  logic [7:0] dcred,
   input  credit_t    cred,
   output logic       ok
);

   logic [8:0]  hdr_s;
   logic [12:0] dat_s;
   logic        legal_s;

   // Pick the header/data credit pair of the requested class.
   always_comb begin
      hdr_s   = 9'd0;
      dat_s   = 13'd0;
      legal_s = 1'b1;
      case (cls)
         CLS_P: begin
            hdr_s = cred.ph;
            dat_s = cred.pd;
         end
         CLS_NP: begin
            hdr_s = cred.nph;
            dat_s = cred.npd;
         end
         CLS_CPL: begin
            hdr_s = cred.cplh;
            dat_s = cred.cpld;
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase
   end

   assign ok = legal_s & hdr_ok(hdr_s) & data_ok(dat_s, dcred);

endmodule

// File: rtl/pcie_tx_arb_chk.sv
// Protocol properties of the TX arbiter: grant exclusivity and owner request stability.
module pcie_tx_arb_chk
   import pcie_tx_pkg::*;
(
   input logic       clk,
   input logic       rst,
   input arb_state_e state,
   input logic       owner,
   input logic       req_a,
   input logic       req_b,
   input logic       gnt_a,
   input logic       gnt_b,
   input logic       adv_a,
   input logic       adv_b
);

   a_gnt_mutex: assert property (@(posedge clk) disable iff (rst) !(gnt_a && gnt_b));
   a_adv_a_gnt: assert property (@(posedge clk) disable iff (rst) adv_a |-> gnt_a);
   a_adv_b_gnt: assert property (@(posedge clk) disable iff (rst) adv_b |-> gnt_b);
   // The owner must keep its request up while the core has not yet accepted it.
   a_req_held:  assert property (@(posedge clk) disable iff (rst)
                                 (state == ST_REQ) |-> (owner ? req_b : req_a));

endmodule

// File: rtl/pcie_tx_arb.sv
// Two-requester arbiter for the PCIe core VC0 TX port with credit gating,
// fair alternation, recheck handling and a request timeout.
module pcie_tx_arb
   import pcie_tx_pkg::*;
#(
   parameter int TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic        sys_clk_125,
   input  logic        rst,
   input  logic        req_a,
   input  logic        req_b,
   input  logic [1:0]  type_a,
   input  logic [1:0]  type_b,
   input  logic [7:0]  dcred_a,
   input  logic [7:0]  dcred_b,
   input  logic [63:0] data_a,
   input  logic [63:0] data_b,
   input  logic        st_a,
   input  logic        st_b,
   input  logic        end_a,
   input  logic        end_b,
   input  logic        dwen_a,
   input  logic        dwen_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic        adv_a,
   output logic        adv_b,
   input  logic        tx_val,
   input  logic        tx_rdy_vc0,
   input  logic        tx_ca_p_recheck_vc0,
   input  logic        tx_ca_cpl_recheck_vc0,
   input  logic [8:0]  tx_ca_ph_vc0,
   input  logic [8:0]  tx_ca_nph_vc0,
   input  logic [8:0]  tx_ca_cplh_vc0,
   input  logic [12:0] tx_ca_pd_vc0,
   input  logic [12:0] tx_ca_npd_vc0,
   input  logic [12:0] tx_ca_cpld_vc0,
   output logic        tx_req_vc0,
   output logic        tx_st_vc0,
   output logic        tx_end_vc0,
   output logic        tx_dwen_vc0,
   output logic [63:0] tx_data_vc0,
   output logic        abort_err
);

   localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

   arb_state_e     state_r, state_nx_s;
   logic           owner_r, owner_nx_s;       // 0 = A, 1 = B
   tlp_cls_e       owner_cls_r, owner_cls_nx_s;
   logic           prio_r, prio_nx_s;         // 0 = A wins a tie
   logic [CW-1:0]  wait_cnt_r, cnt_nx_s;
   logic           abort_err_r, abort_nx_s;

   credit_t        cred_s;
   logic           ok_a_s, ok_b_s;
   logic           elig_a_s, elig_b_s;
   logic           recheck_s;
   logic           own_end_s;

   assign cred_s = '{ph:   tx_ca_ph_vc0,   nph: tx_ca_nph_vc0, cplh: tx_ca_cplh_vc0,
                     pd:   tx_ca_pd_vc0,   npd: tx_ca_npd_vc0, cpld: tx_ca_cpld_vc0};

   pcie_credit_chk u_cred_a (
      .cls   (tlp_cls_e'(type_a)),
      .dcred (dcred_a),
      .cred  (cred_s),
      .ok    (ok_a_s)
   );

   pcie_credit_chk u_cred_b (
      .cls   (tlp_cls_e'(type_b)),
      .dcred (dcred_b),
      .cred  (cred_s),
      .ok    (ok_b_s)
   );

   assign elig_a_s  = req_a & ok_a_s;
   assign elig_b_s  = req_b & ok_b_s;
   assign recheck_s = (tx_ca_p_recheck_vc0   && (owner_cls_r == CLS_P)) ||
                      (tx_ca_cpl_recheck_vc0 && (owner_cls_r == CLS_CPL));
   assign own_end_s = owner_r ? end_b : end_a;
   assign abort_err = abort_err_r;

   // State, ownership, fairness pointer and timeout counter.
   always_ff @(posedge sys_clk_125 or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         owner_r     <= 1'b0;
         owner_cls_r <= CLS_P;
         prio_r      <= 1'b0;
         wait_cnt_r  <= '0;
         abort_err_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         owner_r     <= owner_nx_s;
         owner_cls_r <= owner_cls_nx_s;
         prio_r      <= prio_nx_s;
         wait_cnt_r  <= cnt_nx_s;
         abort_err_r <= abort_nx_s;
      end
   end

   // Next-state logic and the combinational core/requester handshake.
   always_comb begin
      state_nx_s     = state_r;
      owner_nx_s     = owner_r;
      owner_cls_nx_s = owner_cls_r;
      prio_nx_s      = prio_r;
      cnt_nx_s       = '0;
      abort_nx_s     = 1'b0;
      tx_req_vc0     = 1'b0;
      tx_st_vc0      = 1'b0;
      tx_end_vc0     = 1'b0;
      tx_dwen_vc0    = 1'b0;
      tx_data_vc0    = 64'd0;
      gnt_a          = 1'b0;
      gnt_b          = 1'b0;
      adv_a          = 1'b0;
      adv_b          = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (elig_a_s && (!elig_b_s || !prio_r)) begin
               owner_nx_s     = 1'b0;
               owner_cls_nx_s = tlp_cls_e'(type_a);
               state_nx_s     = ST_REQ;
            end else if (elig_b_s) begin
               owner_nx_s     = 1'b1;
               owner_cls_nx_s = tlp_cls_e'(type_b);
               state_nx_s     = ST_REQ;
            end else begin
               state_nx_s     = ST_IDLE;
            end
         end
         ST_REQ: begin
            tx_req_vc0 = 1'b1;
            cnt_nx_s   = wait_cnt_r + CW'(1);
            // A recheck means the credits we judged on may be stale: rearbitrate.
            if (recheck_s) begin
               state_nx_s = ST_IDLE;
            end else if (tx_rdy_vc0) begin
               state_nx_s = ST_XFER;
               gnt_a      = ~owner_r;
               gnt_b      = owner_r;
            end else if (wait_cnt_r == CW'(TO_CYCLES - 1)) begin
               state_nx_s = ST_IDLE;
               abort_nx_s = 1'b1;
               prio_nx_s  = ~prio_r;
            end else begin
               state_nx_s = ST_REQ;
            end
         end
         ST_XFER: begin
            gnt_a       = ~owner_r;
            gnt_b       = owner_r;
            adv_a       = ~owner_r & tx_val;
            adv_b       = owner_r & tx_val;
            tx_data_vc0 = owner_r ? data_b : data_a;
            tx_st_vc0   = owner_r ? st_b : st_a;
            tx_end_vc0  = own_end_s;
            tx_dwen_vc0 = owner_r ? dwen_b : dwen_a;
            if (tx_val && own_end_s) begin
               state_nx_s = ST_IDLE;
               prio_nx_s  = ~owner_r;
            end else begin
               state_nx_s = ST_XFER;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   pcie_tx_arb_chk u_arb_chk (
      .clk   (sys_clk_125),
      .rst   (rst),
      .state (state_r),
      .owner (owner_r),
      .req_a (req_a),
      .req_b (req_b),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b),
      .adv_a (adv_a),
      .adv_b (adv_b)
   );

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Self-checking bench for pcie_tx_arb: eligibility table, directed corner sequences
// and randomized transactions against a transaction-level arbitration model.
module tb_pcie_tx_arb;

   logic        sys_clk_125 = 1'b0;
   logic        rst = 1'b1;
   logic        req_a, req_b, st_a, st_b, end_a, end_b, dwen_a, dwen_b;
   logic [1:0]  type_a, type_b;
   logic [7:0]  dcred_a, dcred_b;
   logic [63:0] data_a, data_b, tx_data_vc0;
   logic        gnt_a, gnt_b, adv_a, adv_b, abort_err;
   logic        tx_val, tx_rdy_vc0, tx_ca_p_recheck_vc0, tx_ca_cpl_recheck_vc0;
   logic [8:0]  tx_ca_ph_vc0, tx_ca_nph_vc0, tx_ca_cplh_vc0;
   logic [12:0] tx_ca_pd_vc0, tx_ca_npd_vc0, tx_ca_cpld_vc0;
   logic        tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_dwen_vc0;

   int checks = 0;
   int errors = 0;
   bit prio_b;          // model: B wins the next tie
   int hc[3];           // model header credits per class, -1 = infinite
   int dc[3];           // model data credits per class, -1 = infinite

   typedef struct {
      logic [1:0]  ty;
      logic [7:0]  dc;
      logic [8:0]  h;
      logic [12:0] d;
      bit          exp;
   } vec_t;
   vec_t vt[12];

   always #5 sys_clk_125 = ~sys_clk_125;

   pcie_tx_arb dut (
      .sys_clk_125(sys_clk_125), .rst(rst),
      .req_a(req_a), .req_b(req_b), .type_a(type_a), .type_b(type_b),
      .dcred_a(dcred_a), .dcred_b(dcred_b), .data_a(data_a), .data_b(data_b),
      .st_a(st_a), .st_b(st_b), .end_a(end_a), .end_b(end_b),
      .dwen_a(dwen_a), .dwen_b(dwen_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .adv_a(adv_a), .adv_b(adv_b),
      .tx_val(tx_val), .tx_rdy_vc0(tx_rdy_vc0),
      .tx_ca_p_recheck_vc0(tx_ca_p_recheck_vc0), .tx_ca_cpl_recheck_vc0(tx_ca_cpl_recheck_vc0),
      .tx_ca_ph_vc0(tx_ca_ph_vc0), .tx_ca_nph_vc0(tx_ca_nph_vc0), .tx_ca_cplh_vc0(tx_ca_cplh_vc0),
      .tx_ca_pd_vc0(tx_ca_pd_vc0), .tx_ca_npd_vc0(tx_ca_npd_vc0), .tx_ca_cpld_vc0(tx_ca_cpld_vc0),
      .tx_req_vc0(tx_req_vc0), .tx_st_vc0(tx_st_vc0), .tx_end_vc0(tx_end_vc0),
      .tx_dwen_vc0(tx_dwen_vc0), .tx_data_vc0(tx_data_vc0), .abort_err(abort_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk_125);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clr_inputs();
      req_a = 1'b0; req_b = 1'b0; type_a = 2'd0; type_b = 2'd0;
      dcred_a = 8'd0; dcred_b = 8'd0; data_a = 64'd0; data_b = 64'd0;
      st_a = 1'b0; st_b = 1'b0; end_a = 1'b0; end_b = 1'b0; dwen_a = 1'b0; dwen_b = 1'b0;
      tx_val = 1'b0; tx_rdy_vc0 = 1'b0; tx_ca_p_recheck_vc0 = 1'b0; tx_ca_cpl_recheck_vc0 = 1'b0;
      tx_ca_ph_vc0 = 9'd0; tx_ca_nph_vc0 = 9'd0; tx_ca_cplh_vc0 = 9'd0;
      tx_ca_pd_vc0 = 13'd0; tx_ca_npd_vc0 = 13'd0; tx_ca_cpld_vc0 = 13'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      settle();
      chk("rst_outs", {tx_req_vc0, gnt_a, gnt_b, adv_a, adv_b, tx_st_vc0, tx_end_vc0,
                       tx_dwen_vc0, abort_err}, 64'd0);
      chk("rst_data", tx_data_vc0, 64'd0);
      tick();
      rst = 1'b0;
      clr_inputs();
      prio_b = 1'b0;
   endtask

   task automatic apply_credits();
      tx_ca_ph_vc0   = (hc[0] < 0) ? 9'h100 : 9'(hc[0]);
      tx_ca_nph_vc0  = (hc[1] < 0) ? 9'h100 : 9'(hc[1]);
      tx_ca_cplh_vc0 = (hc[2] < 0) ? 9'h100 : 9'(hc[2]);
      tx_ca_pd_vc0   = (dc[0] < 0) ? 13'h1000 : 13'(dc[0]);
      tx_ca_npd_vc0  = (dc[1] < 0) ? 13'h1000 : 13'(dc[1]);
      tx_ca_cpld_vc0 = (dc[2] < 0) ? 13'h1000 : 13'(dc[2]);
   endtask

   function automatic bit m_elig(input bit rq, input int ty, input int need);
      if (!rq || ty == 3) return 1'b0;
      return (hc[ty] != 0) && (dc[ty] < 0 || dc[ty] >= need);
   endfunction

   // In REQ: wait `delay` cycles without tx_rdy, then raise it and expect the grant.
   task automatic req_phase(input bit who, input int delay);
      st_a = 1'b1; st_b = 1'b1; end_a = 1'b1; end_b = 1'b1; tx_val = 1'b1;
      data_a = {$urandom, $urandom}; data_b = {$urandom, $urandom};
      for (int d = 0; d < delay; d++) begin
         tx_rdy_vc0 = 1'b0;
         settle();
         chk("req_wait", {tx_req_vc0, gnt_a, gnt_b, adv_a, adv_b, tx_st_vc0, tx_end_vc0,
                          tx_dwen_vc0}, 64'h80);
         tick();
      end
      tx_rdy_vc0 = 1'b1;
      settle();
      chk("req_grant", {tx_req_vc0, gnt_a, gnt_b, adv_a, adv_b, tx_st_vc0, tx_end_vc0,
                        tx_dwen_vc0}, {56'd0, 1'b1, !who, who, 5'd0});
      chk("req_data0", tx_data_vc0, 64'd0);
      tick();
      tx_rdy_vc0 = 1'b0;
   endtask

   // In XFER: play `nb` beats for the owner; mode 0 = always valid, 1 = alternating, 2 = random.
   task automatic xfer(input bit who, input int nb, input int mode);
      int k = 0, advs = 0, ends = 0, cyc = 0;
      bit v, s, e, w;
      logic [63:0] pat;
      logic [31:0] base = $urandom;
      while (k < nb && cyc < 40) begin
         v   = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         pat = {base, 32'(k)};
         s   = (k == 0);
         e   = (k == nb - 1);
         w   = (k % 2 == 1);
         data_a = who ? ~pat : pat;  data_b = who ? pat : ~pat;
         st_a   = who ? !s : s;      st_b   = who ? s : !s;
         end_a  = who ? !e : e;      end_b  = who ? e : !e;
         dwen_a = who ? !w : w;      dwen_b = who ? w : !w;
         tx_val = v;
         settle();
         chk("xfer_ctl", {tx_req_vc0, gnt_a, gnt_b, adv_a, adv_b, tx_st_vc0, tx_end_vc0,
                          tx_dwen_vc0}, {56'd0, 1'b0, !who, who, v && !who, v && who, s, e, w});
         chk("xfer_data", tx_data_vc0, pat);
         if (who ? adv_b : adv_a) advs++;
         if (tx_end_vc0 && tx_val) ends++;
         if (v) k++;
         cyc++;
         tick();
      end
      chk("xfer_done", 64'(k), 64'(nb));
      chk("adv_count", 64'(advs), 64'(nb));
      chk("end_once", 64'(ends), 64'd1);
      tx_val = 1'b0; st_a = 1'b0; st_b = 1'b0; end_a = 1'b0; end_b = 1'b0;
      dwen_a = 1'b0; dwen_b = 1'b0;
      settle();
      chk("gnt_released", {gnt_a, gnt_b, tx_req_vc0}, 64'd0);
      prio_b = !who;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, pulses;
      bit ra, rb, ea, eb, win;
      int ta, tb, na, nb;
      bit ord[4];

      vt[0]  = '{2'd0, 8'd4,   9'd2,    13'd10,    1'b1};
      vt[1]  = '{2'd0, 8'd4,   9'd0,    13'd10,    1'b0};
      vt[2]  = '{2'd0, 8'd4,   9'd1,    13'd3,     1'b0};
      vt[3]  = '{2'd0, 8'd4,   9'd1,    13'd4,     1'b1};
      vt[4]  = '{2'd1, 8'd3,   9'd1,    13'd2,     1'b0};
      vt[5]  = '{2'd1, 8'd3,   9'd1,    13'h1000,  1'b1};
      vt[6]  = '{2'd2, 8'd0,   9'd1,    13'd0,     1'b1};
      vt[7]  = '{2'd2, 8'hFF,  9'h100,  13'h0FF,   1'b1};
      vt[8]  = '{2'd2, 8'hFF,  9'h100,  13'h0FE,   1'b0};
      vt[9]  = '{2'd3, 8'd0,   9'h100,  13'h1000,  1'b0};
      vt[10] = '{2'd1, 8'd0,   9'd0,    13'h1000,  1'b0};
      vt[11] = '{2'd0, 8'd200, 9'd5,    13'd200,   1'b1};
      ord = '{1'b0, 1'b1, 1'b0, 1'b1};

      clr_inputs();
      do_reset();

      // Eligibility table: A alone, credits only on its own class.
      for (int i = 0; i < 12; i++) begin
         tx_ca_ph_vc0 = 9'd0; tx_ca_nph_vc0 = 9'd0; tx_ca_cplh_vc0 = 9'd0;
         tx_ca_pd_vc0 = 13'd0; tx_ca_npd_vc0 = 13'd0; tx_ca_cpld_vc0 = 13'd0;
         if (vt[i].ty == 2'd0 || vt[i].ty == 2'd3) begin tx_ca_ph_vc0 = vt[i].h;   tx_ca_pd_vc0 = vt[i].d;   end
         if (vt[i].ty == 2'd1 || vt[i].ty == 2'd3) begin tx_ca_nph_vc0 = vt[i].h;  tx_ca_npd_vc0 = vt[i].d;  end
         if (vt[i].ty == 2'd2 || vt[i].ty == 2'd3) begin tx_ca_cplh_vc0 = vt[i].h; tx_ca_cpld_vc0 = vt[i].d; end
         req_a = 1'b1; req_b = 1'b0; type_a = vt[i].ty; dcred_a = vt[i].dc;
         tick();
         settle();
         chk($sformatf("elig_vec%0d", i), tx_req_vc0, vt[i].exp);
         if (vt[i].exp) begin
            req_phase(1'b0, 0);
            xfer(1'b0, 1, 0);
         end
         req_a = 1'b0;
      end

      // Posted TLP, tx_rdy after 3 cycles, 3 beats.
      do_reset();
      tx_ca_ph_vc0 = 9'd2; tx_ca_pd_vc0 = 13'd10;
      req_a = 1'b1; type_a = 2'd0; dcred_a = 8'd4;
      tick();
      req_phase(1'b0, 3);
      xfer(1'b0, 3, 0);
      chk("s31_idle", tx_req_vc0, 1'b0);
      req_a = 1'b0;

      // Both always eligible: strict alternation from A.
      do_reset();
      tx_ca_ph_vc0 = 9'h100; tx_ca_pd_vc0 = 13'h1000;
      req_a = 1'b1; req_b = 1'b1; dcred_a = 8'd1; dcred_b = 8'd1;
      for (int t = 0; t < 4; t++) begin
         tick();
         req_phase(ord[t], 1);
         xfer(ord[t], 2, 0);
      end
      req_a = 1'b0; req_b = 1'b0;

      // Non-posted A starved of data credit; completion B goes first.
      do_reset();
      type_a = 2'd1; dcred_a = 8'd3; tx_ca_nph_vc0 = 9'd1; tx_ca_npd_vc0 = 13'd2;
      type_b = 2'd2; dcred_b = 8'd1; tx_ca_cplh_vc0 = 9'd1; tx_ca_cpld_vc0 = 13'd5;
      req_a = 1'b1; req_b = 1'b1;
      tick();
      req_phase(1'b1, 0);
      xfer(1'b1, 2, 0);
      req_b = 1'b0;
      tick();
      settle();
      chk("s33_a_blocked", tx_req_vc0, 1'b0);
      tx_ca_npd_vc0 = 13'h1000;
      tick();
      req_phase(1'b0, 0);
      xfer(1'b0, 1, 0);
      req_a = 1'b0;

      // Recheck: wrong-class recheck is ignored, matching one drops the request.
      do_reset();
      tx_ca_ph_vc0 = 9'h100; tx_ca_pd_vc0 = 13'h1000;
      req_a = 1'b1; dcred_a = 8'd2; dcred_b = 8'd2;
      tick();
      tx_ca_cpl_recheck_vc0 = 1'b1;
      tick();
      tx_ca_cpl_recheck_vc0 = 1'b0;
      settle();
      chk("s34_cpl_recheck_ignored", tx_req_vc0, 1'b1);
      tx_ca_p_recheck_vc0 = 1'b1;
      tick();
      tx_ca_p_recheck_vc0 = 1'b0; tx_rdy_vc0 = 1'b1; req_b = 1'b1;
      settle();
      chk("s34_dropped", {tx_req_vc0, gnt_a, gnt_b}, 64'd0);
      tick();
      req_phase(1'b0, 0);
      xfer(1'b0, 1, 0);
      req_a = 1'b0; req_b = 1'b0;

      // Timeout: A waits TO_CYCLES cycles, aborts, then B is served.
      do_reset();
      tx_ca_ph_vc0 = 9'h100; tx_ca_pd_vc0 = 13'h1000;
      req_a = 1'b1; req_b = 1'b1;
      tick();
      bad = 0; pulses = 0;
      for (int i = 0; i < 256; i++) begin
         settle();
         if (tx_req_vc0 !== (i < 255) || abort_err !== (i == 255) || gnt_a || gnt_b) bad++;
         if (abort_err) pulses++;
         tick();
      end
      chk("s35_profile_bad_cycles", 64'(bad), 64'd0);
      chk("s35_abort_pulses", 64'(pulses), 64'd1);
      prio_b = !prio_b;
      req_phase(1'b1, 0);
      xfer(1'b1, 1, 0);
      req_a = 1'b0; req_b = 1'b0;

      // Alternating tx_val over 4 beats, then reset in the middle of a transfer.
      do_reset();
      tx_ca_ph_vc0 = 9'h100; tx_ca_pd_vc0 = 13'h1000;
      tx_ca_cplh_vc0 = 9'h100; tx_ca_cpld_vc0 = 13'h1000;
      req_a = 1'b1;
      tick();
      req_phase(1'b0, 0);
      xfer(1'b0, 4, 1);
      req_a = 1'b0; req_b = 1'b1; type_b = 2'd2;
      tick();
      req_phase(1'b1, 0);
      data_b = 64'h0123_4567_89AB_CDEF; st_b = 1'b1; end_b = 1'b0; tx_val = 1'b1;
      tick();
      st_b = 1'b0; dwen_b = 1'b1;
      rst = 1'b1;
      settle();
      chk("s36_rst_outs", {tx_req_vc0, gnt_a, gnt_b, adv_a, adv_b, tx_st_vc0, tx_end_vc0,
                           tx_dwen_vc0, abort_err}, 64'd0);
      chk("s36_rst_data", tx_data_vc0, 64'd0);
      tick();
      rst = 1'b0;
      clr_inputs();
      prio_b = 1'b0;

      // Randomized transactions against the arbitration model.
      for (int n = 0; n < 60; n++) begin
         for (int c = 0; c < 3; c++) begin
            hc[c] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
            dc[c] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 12));
         end
         apply_credits();
         ra = ($urandom_range(0, 3) != 0); rb = ($urandom_range(0, 3) != 0);
         ta = int'($urandom_range(0, 3));  tb = int'($urandom_range(0, 3));
         na = int'($urandom_range(0, 10)); nb = int'($urandom_range(0, 10));
         req_a = ra; req_b = rb; type_a = 2'(ta); type_b = 2'(tb);
         dcred_a = 8'(na); dcred_b = 8'(nb);
         ea = m_elig(ra, ta, na);
         eb = m_elig(rb, tb, nb);
         win = (ea && eb) ? prio_b : eb;
         tick();
         settle();
         chk($sformatf("rnd%0d_req", n), tx_req_vc0, ea || eb);
         if (ea || eb) begin
            req_phase(win, int'($urandom_range(0, 3)));
            xfer(win, int'($urandom_range(1, 4)), 2);
         end
      end
      req_a = 1'b0; req_b = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_tx_arb.md
PCIE_TX_ARB -- requirements
Module: pcie_tx_arb

Interface
REQ-001 Parameter TO_CYCLES, default 255, is the maximum number of cycles the block waits in REQ for tx_rdy_vc0 before aborting.
REQ-002 sys_clk_125  in  1  PCIe core user clock; all logic runs on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_a / req_b  in  1 each  requester has a complete TLP pending; held until its end beat is accepted.
REQ-005 type_a / type_b  in  2 each  TLP class: 0 = posted, 1 = non-posted, 2 = completion; 3 is illegal and is never granted.
REQ-006 dcred_a / dcred_b  in  8 each  data credits the TLP needs; 0 means header-only.
REQ-007 data_a / data_b  in  64 each; st_a/st_b, end_a/end_b, dwen_a/dwen_b  in  1 each  TLP beat from each requester.
REQ-008 gnt_a / gnt_b  out  1 each  requester owns the core TX port, from tx_rdy_vc0 until its end beat is accepted.
REQ-009 adv_a / adv_b  out  1 each  the current beat is consumed this cycle; the requester presents its next beat on the following cycle.
REQ-010 tx_val, tx_rdy_vc0, tx_ca_p_recheck_vc0, tx_ca_cpl_recheck_vc0  in  1 each  core TX handshake signals.
REQ-011 tx_ca_ph_vc0, tx_ca_nph_vc0, tx_ca_cplh_vc0  in  9 each; tx_ca_pd_vc0, tx_ca_npd_vc0, tx_ca_cpld_vc0  in  13 each  available credits; the MSB set means infinite.
REQ-012 tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_dwen_vc0  out  1 each; tx_data_vc0  out  64  signals driven to the core.
REQ-013 abort_err  out  1  one-cycle pulse on a timeout abort.

Function
REQ-014 States: IDLE, REQ, XFER.
REQ-015 A requester is eligible when all of the following hold:
- its req is high;
- its type is not 3;
- the header credit for its class is at least 1 or infinite;
- the data credit for its class is at least its dcred or infinite (the compare is zero-extended to 13 bits).
REQ-016 IDLE: if exactly one requester is eligible, it is selected; if both are eligible, the one not served last wins; after reset, A has priority; a selection moves the FSM to REQ.
REQ-017 The owner index and owner class are registered on the transition into REQ and stay stable until the FSM returns to IDLE.
REQ-018 REQ: tx_req_vc0 = 1; on tx_rdy_vc0 = 1, go to XFER and assert the owner's gnt in the same cycle.
REQ-019 REQ: on tx_ca_p_recheck_vc0 with a posted owner, or tx_ca_cpl_recheck_vc0 with a completion owner, drop tx_req_vc0 and return to IDLE; the priority pointer is unchanged.
REQ-020 REQ: a wait counter increments every cycle; when it reaches TO_CYCLES, return to IDLE, pulse abort_err, and flip the priority pointer.
REQ-021 XFER: tx_req_vc0 = 0; tx_data_vc0, tx_st_vc0, tx_end_vc0 and tx_dwen_vc0 are combinationally muxed from the owner; adv_owner = tx_val.
REQ-022 XFER: when adv is 1 and the owner's end is 1, return to IDLE, record the owner as last served, and deassert gnt on the next cycle.
REQ-023 Outside XFER, tx_st_vc0, tx_end_vc0 and tx_dwen_vc0 are 0 and tx_data_vc0 is all zeros.
REQ-024 gnt_a and gnt_b are never high together; adv is never high without the matching gnt.
REQ-025 Minimum latency: eligible in IDLE -> tx_req_vc0 on the next cycle; tx_rdy_vc0 -> gnt in the same cycle.
REQ-026 If the owner drops req during REQ, the request continues unchanged; the protocol forbids this, and assertions flag it.

Reset
REQ-027 While rst is high:
- state = IDLE and priority = A;
- the wait counter is 0;
- all outputs are 0.
REQ-028 Assertion of rst during XFER abandons the TLP immediately; no beat is forwarded on the cycle after rst rises.

Structure
REQ-029 The class encodings, state encoding and the TO_CYCLES default are placed in the shared package pcie_tx_pkg.
REQ-030 The sub-module pcie_credit_chk computes eligibility for one requester (class, dcred, credit vector -> ok) and is instantiated twice.

Verification
REQ-031 Scenario: A posted with dcred = 4, tx_ca_ph = 2, tx_ca_pd = 10, tx_rdy after 3 cycles, 3 beats with tx_val = 1 -> gnt_a rises with tx_rdy, exactly 3 adv_a pulses, return to IDLE.
REQ-032 Scenario: A and B eligible every cycle for 4 TLPs -> grant order A, B, A, B.
REQ-033 Scenario: A non-posted, tx_ca_npd = 2, dcred_a = 3, B completion eligible -> B is granted, A is not granted; after tx_ca_npd = 13'h1000 (infinite), A is granted.
REQ-034 Scenario: tx_ca_p_recheck_vc0 pulsed in REQ for a posted owner -> tx_req_vc0 low on the next cycle, state IDLE, no gnt, pointer unchanged.
REQ-035 Scenario: tx_rdy_vc0 never asserted, TO_CYCLES = 255 -> one abort_err pulse 255 cycles after entering REQ; the other requester is served next.
REQ-036 Scenario: tx_val toggling 1, 0 during a 4-beat XFER -> adv follows tx_val, tx_end_vc0 is accepted once, gnt stays high until then; rst mid-XFER -> all outputs 0 within the same cycle.
